// File: rtl/regfile_writeback.sv
// Write-back arbiter for the register bank: merges ALU and queued load results
// onto one write port, diverts r15 results to the PC, and tracks pending writes.
module regfile_writeback #(
  parameter int LOAD_FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rstN,
  input  logic                                issueValid,
  input  logic [3:0]                          issueAddress,
  input  logic                                aluValid,
  input  logic [3:0]                          aluAddress,
  input  logic [31:0]                         aluData,
  output logic                                aluReady,
  input  logic                                loadValid,
  input  logic [3:0]                          loadAddress,
  input  logic [31:0]                         loadData,
  output logic                                loadReady,
  output logic                                writeEnabled,
  output logic [3:0]                          writeAddress,
  output logic [31:0]                         writeData,
  output logic                                pcWriteValid,
  output logic [31:0]                         pcWriteData,
  input  logic [3:0]                          queryAddress1,
  input  logic [3:0]                          queryAddress2,
  output logic                                hazard1,
  output logic                                hazard2,
  output logic [15:0]                         pending,
  output logic [$clog2(LOAD_FIFO_DEPTH):0]    loadCount
);

  localparam int PW = $clog2(LOAD_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] PC_REG = 4'd15;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t         fifo_mem [LOAD_FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              fifo_full, fifo_empty;
  logic              enq, deq;

  logic              win_valid;
  wb_entry_t         win;

  logic              write_en_q, pc_valid_q;
  logic [3:0]        write_addr_q;
  logic [31:0]       write_data_q, pc_data_q;
  logic [15:0]       pending_q, pending_d;

  assign fifo_full  = (count_q == CW'(LOAD_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign loadReady  = ~fifo_full;
  assign aluReady   = ~fifo_full;
  assign enq        = loadValid & ~fifo_full;

  // A full FIFO takes the port so a continuous ALU stream cannot starve loads.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a path
    // that skips the assignment infers a latch.
    win_valid = 1'b0;
    win       = '{addr: aluAddress, data: aluData};
    deq       = 1'b0;
    if (fifo_full) begin
      win_valid = 1'b1;
      win       = fifo_mem[rd_ptr_q];
      deq       = 1'b1;
    end else if (aluValid) begin
      win_valid = 1'b1;
    end else if (!fifo_empty) begin
      win_valid = 1'b1;
      win       = fifo_mem[rd_ptr_q];
      deq       = 1'b1;
    end
  end

  always_comb begin
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the FIFO storage is deliberately not reset; occupancy is governed
  // solely by the pointers and count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr_q] <= '{addr: loadAddress, data: loadData};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      pc_valid_q   <= 1'b0;
      pc_data_q    <= '0;
    end else begin
      write_en_q <= 1'b0;
      pc_valid_q <= 1'b0;
      if (win_valid) begin
        if (win.addr == PC_REG) begin
          pc_valid_q <= 1'b1;
          pc_data_q  <= win.data;
        end else begin
          write_en_q   <= 1'b1;
          write_addr_q <= win.addr;
          write_data_q <= win.data;
        end
      end
    end
  end

  // The clear lands on the same edge the bank captures the data; set wins a tie.
  always_comb begin
    pending_d = pending_q;
    if (write_en_q) pending_d[write_addr_q] = 1'b0;
    if (issueValid && issueAddress != PC_REG) pending_d[issueAddress] = 1'b1;
    pending_d[15] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign writeEnabled = write_en_q;
  assign writeAddress = write_addr_q;
  assign writeData    = write_data_q;
  assign pcWriteValid = pc_valid_q;
  assign pcWriteData  = pc_data_q;
  assign pending      = pending_q;
  assign loadCount    = count_q;
  assign hazard1      = (queryAddress1 != PC_REG) & pending_q[queryAddress1];
  assign hazard2      = (queryAddress2 != PC_REG) & pending_q[queryAddress2];

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: a behavioural model pushes the expected port
// state each edge; a negedge monitor pops and compares, plus directed checks.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk, rstN;
  logic        issueValid;
  logic [3:0]  issueAddress;
  logic        aluValid;
  logic [3:0]  aluAddress;
  logic [31:0] aluData;
  logic        aluReady;
  logic        loadValid;
  logic [3:0]  loadAddress;
  logic [31:0] loadData;
  logic        loadReady;
  logic        writeEnabled;
  logic [3:0]  writeAddress;
  logic [31:0] writeData;
  logic        pcWriteValid;
  logic [31:0] pcWriteData;
  logic [3:0]  queryAddress1, queryAddress2;
  logic        hazard1, hazard2;
  logic [15:0] pending;
  logic [2:0]  loadCount;

  regfile_writeback #(.LOAD_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN),
    .issueValid(issueValid), .issueAddress(issueAddress),
    .aluValid(aluValid), .aluAddress(aluAddress), .aluData(aluData), .aluReady(aluReady),
    .loadValid(loadValid), .loadAddress(loadAddress), .loadData(loadData), .loadReady(loadReady),
    .writeEnabled(writeEnabled), .writeAddress(writeAddress), .writeData(writeData),
    .pcWriteValid(pcWriteValid), .pcWriteData(pcWriteData),
    .queryAddress1(queryAddress1), .queryAddress2(queryAddress2),
    .hazard1(hazard1), .hazard2(hazard2),
    .pending(pending), .loadCount(loadCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        we;
    logic        pcv;
    logic [3:0]  addr;
    logic [31:0] data;
  } out_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } ld_t;

  out_t        expq[$];
  ld_t         mq[$];
  logic [15:0] m_pend;
  out_t        m_cur;

  // Reference model: FIFO as a queue, winner chosen from pre-edge state.
  always @(posedge clk or negedge rstN) begin
    out_t nx;
    ld_t  hd;
    bit   full;
    bit   have;
    if (!rstN) begin
      mq.delete();
      expq.delete();
      m_pend = '0;
      m_cur  = '{1'b0, 1'b0, 4'd0, 32'd0};
    end else begin
      full = (mq.size() == DEPTH);
      have = 1'b0;
      nx   = '{1'b0, 1'b0, 4'd0, 32'd0};
      if (full || (!aluValid && mq.size() > 0)) begin
        hd   = mq.pop_front();
        have = 1'b1;
      end else if (aluValid) begin
        hd   = '{aluAddress, aluData};
        have = 1'b1;
      end
      if (have) begin
        if (hd.addr == 4'd15) nx = '{1'b0, 1'b1, hd.addr, hd.data};
        else                  nx = '{1'b1, 1'b0, hd.addr, hd.data};
      end
      if (loadValid && !full) mq.push_back('{loadAddress, loadData});
      if (m_cur.we) m_pend[m_cur.addr] = 1'b0;
      if (issueValid && issueAddress != 4'd15) m_pend[issueAddress] = 1'b1;
      m_cur = nx;
      expq.push_back(nx);
    end
  end

  always @(negedge clk) begin
    out_t e;
    if (expq.size() > 0) e = expq.pop_front();
    else                 e = '{1'b0, 1'b0, 4'd0, 32'd0};
    check("mon_we", writeEnabled, e.we);
    check("mon_pcv", pcWriteValid, e.pcv);
    if (e.we) begin
      check("mon_waddr", writeAddress, e.addr);
      check("mon_wdata", writeData, e.data);
    end
    if (e.pcv) check("mon_pcdata", pcWriteData, e.data);
    check("mon_count", loadCount, mq.size());
    check("mon_alurdy", aluReady, mq.size() != DEPTH);
    check("mon_ldrdy", loadReady, mq.size() != DEPTH);
    check("mon_pending", pending, m_pend);
    check("mon_haz1", hazard1, m_pend[queryAddress1]);
    check("mon_haz2", hazard2, m_pend[queryAddress2]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issueValid = 1'b0;
    aluValid   = 1'b0;
    loadValid  = 1'b0;
  endtask

  initial begin
    int  sent, lsent;
    bit  acc_a, acc_l;
    rstN = 1'b0;
    idle();
    issueAddress = '0; aluAddress = '0; aluData = '0;
    loadAddress = '0; loadData = '0;
    queryAddress1 = 4'd3; queryAddress2 = 4'd15;
    #2;
    check("rst_we", writeEnabled, 1'b0);
    check("rst_count", loadCount, 3'd0);
    check("rst_alurdy", aluReady, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    tick();

    // ALU write with hazard tracking on r3
    issueValid = 1'b1; issueAddress = 4'd3;
    tick();
    idle();
    check("haz_set", hazard1, 1'b1);
    aluValid = 1'b1; aluAddress = 4'd3; aluData = 32'hDEADBEEF;
    tick();
    idle();
    check("alu_we", writeEnabled, 1'b1);
    check("alu_addr", writeAddress, 4'd3);
    check("alu_data", writeData, 32'hDEADBEEF);
    check("haz_hold", hazard1, 1'b1);
    tick();
    check("haz_clear", hazard1, 1'b0);
    check("alu_we_drop", writeEnabled, 1'b0);

    // ALU priority over a queued load
    aluValid = 1'b1; aluAddress = 4'd1; aluData = 32'h11;
    loadValid = 1'b1; loadAddress = 4'd5; loadData = 32'h55;
    tick();
    loadValid = 1'b0;
    check("pri_count", loadCount, 3'd1);
    for (int a = 2; a <= 4; a++) begin
      aluAddress = 4'(a); aluData = 32'(a * 17);
      tick();
    end
    idle();
    tick();
    check("pri_load_addr", writeAddress, 4'd5);
    check("pri_load_data", writeData, 32'h55);
    check("pri_count0", loadCount, 3'd0);
    tick();

    // Fill the FIFO under a continuous ALU stream
    sent = 0; lsent = 0;
    for (int c = 0; c < 8; c++) begin
      aluValid = 1'b1; aluAddress = 4'd9; aluData = 32'hA000 + 32'(sent);
      loadValid = (lsent < DEPTH);
      loadAddress = 4'(10 + lsent); loadData = 32'hB000 + 32'(lsent);
      acc_a = aluReady;
      acc_l = loadReady && loadValid;
      tick();
      if (acc_a) sent++;
      if (acc_l) lsent++;
      if (c == 3) begin
        check("full_count", loadCount, 3'd4);
        check("full_alurdy", aluReady, 1'b0);
      end
      if (c == 4) begin
        check("full_head_addr", writeAddress, 4'd10);
        check("full_head_data", writeData, 32'hB000);
        check("full_alurdy_back", aluReady, 1'b1);
      end
    end
    idle();
    repeat (4) tick();
    check("full_drain", loadCount, 3'd0);

    // PC redirect and ignored issue to r15
    aluValid = 1'b1; aluAddress = 4'd15; aluData = 32'h00000100;
    issueValid = 1'b1; issueAddress = 4'd15;
    tick();
    idle();
    check("pc_valid", pcWriteValid, 1'b1);
    check("pc_data", pcWriteData, 32'h100);
    check("pc_no_we", writeEnabled, 1'b0);
    check("pc_pending", pending, 16'h0000);
    check("pc_haz2", hazard2, 1'b0);
    tick();

    // Set and clear of r7 at the same edge
    queryAddress1 = 4'd7;
    issueValid = 1'b1; issueAddress = 4'd7;
    tick();
    idle();
    aluValid = 1'b1; aluAddress = 4'd7; aluData = 32'h77;
    tick();
    aluValid = 1'b0;
    check("sc_we", writeEnabled, 1'b1);
    issueValid = 1'b1; issueAddress = 4'd7;
    tick();
    idle();
    check("sc_pending7", pending[7], 1'b1);
    check("sc_haz", hazard1, 1'b1);
    aluValid = 1'b1; aluAddress = 4'd7; aluData = 32'h78;
    tick();
    idle();
    tick();
    check("sc_cleared", pending, 16'h0000);

    // Mid-cycle reset with two loads queued and r1/r2 pending
    for (int c = 0; c < 4; c++) begin
      aluValid = 1'b1; aluAddress = 4'd8; aluData = 32'hC0 + 32'(c);
      loadValid = (c < 2); loadAddress = 4'(9 + c); loadData = 32'hD0 + 32'(c);
      issueValid = (c >= 2); issueAddress = 4'(c - 1);
      tick();
    end
    idle();
    check("prerst_count", loadCount, 3'd2);
    check("prerst_pending", pending, 16'h0006);
    #2 rstN = 1'b0;
    #1;
    check("arst_we", writeEnabled, 1'b0);
    check("arst_pcv", pcWriteValid, 1'b0);
    check("arst_pending", pending, 16'h0000);
    check("arst_waddr", writeAddress, 4'd0);
    check("arst_wdata", writeData, 32'd0);
    check("arst_pcdata", pcWriteData, 32'd0);
    check("arst_count", loadCount, 3'd0);
    check("arst_ldrdy", loadReady, 1'b1);
    check("arst_alurdy", aluReady, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    repeat (6) tick();
    check("postrst_count", loadCount, 3'd0);
    check("postrst_we", writeEnabled, 1'b0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
